snake_body: RTL and testbench

SNAKE_BODY -- requirements
Module: snake_body

---
 rtl/snake_body.sv | 134 +++++++++++++
 tb/tb_snake_body.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/snake_body.sv
// Snake body store and move engine: head-first segment list, wall and
// self-collision detection, growth bookkeeping and RUN/DEAD state.
module snake_body #(
   parameter int MAX_LEN  = 100,
   parameter int INIT_LEN = 3,
   parameter int STEP     = 10,
   parameter int START_X  = 450,
   parameter int START_Y  = 270,
   parameter int X_MIN    = 150,
   parameter int X_MAX    = 740,
   parameter int Y_MIN    = 50,
   parameter int Y_MAX    = 490
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic [1:0]    dir_in,
   input  logic          grow,
   input  logic          restart,
   output logic [2999:0] snake_x,
   output logic [2999:0] snake_y,
   output logic [6:0]    snake_length,
   output logic          alive,
   output logic          moved
);

   localparam int SLOTS = 300;

   localparam logic [1:0] D_UP    = 2'd0;
   localparam logic [1:0] D_DOWN  = 2'd1;
   localparam logic [1:0] D_LEFT  = 2'd2;
   localparam logic [1:0] D_RIGHT = 2'd3;

   typedef enum logic {RUN, DEAD} state_t;

   state_t     state;
   logic [9:0] seg_x [MAX_LEN];
   logic [9:0] seg_y [MAX_LEN];
   logic [2:0] gp;
   logic [1:0] cur_dir, req_dir;

   logic [9:0] nx, ny;
   logic       wall, hit, can_grow, go, die;
   logic [6:0] lim, new_len;
   logic [2:0] gp_base, gp_nxt;

   // Candidate head, collision test and growth bookkeeping for this cycle
   always_comb begin
      nx = seg_x[0];
      ny = seg_y[0];
      case (req_dir)
         D_UP:    ny = seg_y[0] - 10'(STEP);
         D_DOWN:  ny = seg_y[0] + 10'(STEP);
         D_LEFT:  nx = seg_x[0] - 10'(STEP);
         default: nx = seg_x[0] + 10'(STEP);
      endcase
      // Underflow wraps to a large value and so trips the upper bound.
      wall = (nx < 10'(X_MIN)) || (nx > 10'(X_MAX)) ||
             (ny < 10'(Y_MIN)) || (ny > 10'(Y_MAX));
      can_grow = (gp != 3'd0) && (snake_length < 7'(MAX_LEN));
      // The tail vacates its slot on a non-growing move, so it is not an obstacle.
      lim = can_grow ? snake_length : snake_length - 7'd1;
      hit = 1'b0;
      for (int i = 0; i < MAX_LEN; i++)
         if ((7'(i) < lim) && (seg_x[i] == nx) && (seg_y[i] == ny)) hit = 1'b1;
      go      = tick && (state == RUN) && !wall && !hit;
      die     = tick && (state == RUN) && (wall || hit);
      new_len = can_grow ? snake_length + 7'd1 : snake_length;
      gp_base = gp;
      if (go && (gp != 3'd0)) gp_base = can_grow ? gp - 3'd1 : 3'd0;
      gp_nxt = gp_base;
      if (grow && (state == RUN) && (gp_base != 3'd7)) gp_nxt = gp_base + 3'd1;
   end

   // Body state machine; slots beyond the live length are kept at zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= RUN;
         alive        <= 1'b1;
         moved        <= 1'b0;
         snake_length <= 7'(INIT_LEN);
         gp           <= 3'd0;
         cur_dir      <= D_RIGHT;
         req_dir      <= D_RIGHT;
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= (i < INIT_LEN) ? 10'(START_X - i*STEP) : 10'd0;
            seg_y[i] <= (i < INIT_LEN) ? 10'(START_Y) : 10'd0;
         end
      end else if (restart) begin
         state        <= RUN;
         alive        <= 1'b1;
         moved        <= 1'b0;
         snake_length <= 7'(INIT_LEN);
         gp           <= 3'd0;
         cur_dir      <= D_RIGHT;
         req_dir      <= D_RIGHT;
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= (i < INIT_LEN) ? 10'(START_X - i*STEP) : 10'd0;
            seg_y[i] <= (i < INIT_LEN) ? 10'(START_Y) : 10'd0;
         end
      end else begin
         moved <= go;
         gp    <= gp_nxt;
         // A direct reversal request is dropped and the previous request kept.
         if (dir_in != (cur_dir ^ 2'd1)) req_dir <= dir_in;
         if (die) begin
            state <= DEAD;
            alive <= 1'b0;
         end
         if (go) begin
            cur_dir      <= req_dir;
            snake_length <= new_len;
            seg_x[0]     <= nx;
            seg_y[0]     <= ny;
            for (int i = 1; i < MAX_LEN; i++) begin
               seg_x[i] <= (7'(i) < new_len) ? seg_x[i-1] : 10'd0;
               seg_y[i] <= (7'(i) < new_len) ? seg_y[i-1] : 10'd0;
            end
         end
      end
   end

   // Segment registers drive the bus directly; slots past MAX_LEN are tied off
   for (genvar g = 0; g < SLOTS; g++) begin : g_bus
      if (g < MAX_LEN) begin : g_live
         assign snake_x[g*10 +: 10] = seg_x[g];
         assign snake_y[g*10 +: 10] = seg_y[g];
      end else begin : g_zero
         assign snake_x[g*10 +: 10] = 10'd0;
         assign snake_y[g*10 +: 10] = 10'd0;
      end
   end

endmodule

// File: tb/tb_snake_body.sv
// Randomized and directed bench for snake_body against a queue-based model.
module tb_snake_body;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          tick = 1'b0;
   logic [1:0]    dir_in = 2'd3;
   logic          grow = 1'b0;
   logic          restart = 1'b0;
   logic [2999:0] snake_x, snake_y;
   logic [6:0]    snake_length;
   logic          alive, moved;

   int checks = 0;
   int errors = 0;

   snake_body dut (
      .clk(clk), .rst(rst), .tick(tick), .dir_in(dir_in), .grow(grow),
      .restart(restart), .snake_x(snake_x), .snake_y(snake_y),
      .snake_length(snake_length), .alive(alive), .moved(moved)
   );

   always #5 clk = ~clk;

   // Model: the body is a head-first list of points.
   int m_x[$];
   int m_y[$];
   int m_pend, m_cur, m_req;
   bit m_alive, m_moved;

   task automatic m_reset();
      m_x = {450, 440, 430};
      m_y = {270, 270, 270};
      m_pend = 0; m_cur = 3; m_req = 3; m_alive = 1; m_moved = 0;
   endtask

   task automatic m_step(bit tk, int d, bit g, bit rs);
      bit was_alive, cg, dead;
      int oc, hx, hy, n;
      if (rs) begin
         m_reset();
         return;
      end
      was_alive = m_alive;
      oc = m_cur;
      m_moved = 0;
      if (m_alive && tk) begin
         hx = m_x[0]; hy = m_y[0];
         case (m_req)
            0: hy = hy - 10;
            1: hy = hy + 10;
            2: hx = hx - 10;
            default: hx = hx + 10;
         endcase
         hx = hx & 1023; hy = hy & 1023;
         cg = (m_pend > 0) && (m_x.size() < 100);
         n = cg ? m_x.size() : m_x.size() - 1;
         dead = (hx < 150) || (hx > 740) || (hy < 50) || (hy > 490);
         for (int i = 0; i < n; i++)
            if (m_x[i] == hx && m_y[i] == hy) dead = 1;
         if (dead) m_alive = 0;
         else begin
            m_x.push_front(hx); m_y.push_front(hy);
            if (cg) m_pend--;
            else begin
               void'(m_x.pop_back()); void'(m_y.pop_back());
               m_pend = 0;
            end
            m_cur = m_req;
            m_moved = 1;
         end
      end
      if (was_alive && g && m_pend < 7) m_pend++;
      if (d != (oc ^ 1)) m_req = d;
   endtask

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
      end
   endtask

   task automatic compare_all();
      int bad, ex, ey;
      chk("length", int'(snake_length), m_x.size());
      chk("alive", int'(alive), int'(m_alive));
      chk("moved", int'(moved), int'(m_moved));
      bad = -1; ex = 0; ey = 0;
      for (int i = 0; i < 300; i++) begin
         ex = (i < m_x.size()) ? m_x[i] : 0;
         ey = (i < m_y.size()) ? m_y[i] : 0;
         if (int'(snake_x[i*10 +: 10]) != ex || int'(snake_y[i*10 +: 10]) != ey) begin
            bad = i;
            break;
         end
      end
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL bus slot %0d act=(%0d,%0d) exp=(%0d,%0d) t=%0t", bad,
                  snake_x[bad*10 +: 10], snake_y[bad*10 +: 10], ex, ey, $time);
      end
   endtask

   task automatic cyc(bit tk, int d, bit g, bit rs);
      @(negedge clk);
      tick = tk; dir_in = 2'(d); grow = g; restart = rs;
      m_step(tk, d, g, rs);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic mv(int d);
      cyc(0, d, 0, 0);
      cyc(1, d, 0, 0);
   endtask

   function automatic int hx(int i); return int'(snake_x[i*10 +: 10]); endfunction
   function automatic int hy(int i); return int'(snake_y[i*10 +: 10]); endfunction

   int d;
   bit tk, g, rs;

   initial begin
      // Reset state
      m_reset();
      @(posedge clk); #1;
      compare_all();
      chk("rst_len", int'(snake_length), 3);
      chk("rst_seg2_x", hx(2), 430);
      @(negedge clk); rst = 1'b1;

      // One tick right
      cyc(1, 3, 0, 0);
      chk("t1_head_x", hx(0), 460);
      chk("t1_seg2_x", hx(2), 440);
      chk("t1_moved", int'(moved), 1);

      // Growth
      cyc(0, 3, 0, 1);
      cyc(0, 3, 1, 0);
      cyc(1, 3, 0, 0);
      chk("grow_len", int'(snake_length), 4);
      chk("grow_tail_x", hx(3), 430);
      cyc(1, 3, 0, 0);
      chk("grow_len2", int'(snake_length), 4);

      // Reversal ignored, then turn up
      cyc(0, 3, 0, 1);
      mv(2);
      chk("rev_head_x", hx(0), 460);
      mv(0);
      chk("up_head_x", hx(0), 460);
      chk("up_head_y", hy(0), 260);

      // Wall death at x=740
      cyc(0, 3, 0, 1);
      repeat (29) cyc(1, 3, 0, 0);
      chk("wall_pre_x", hx(0), 740);
      cyc(1, 3, 0, 0);
      chk("wall_alive", int'(alive), 0);
      chk("wall_frozen_x", hx(0), 740);
      repeat (3) cyc(1, 3, 1, 0);
      chk("dead_len", int'(snake_length), 3);
      cyc(0, 3, 0, 1);
      chk("restart_alive", int'(alive), 1);
      chk("restart_head_x", hx(0), 450);

      // U-turn into own body at length 5
      cyc(0, 3, 1, 0);
      cyc(0, 3, 1, 0);
      cyc(1, 3, 0, 0);
      cyc(1, 3, 0, 0);
      chk("u_len", int'(snake_length), 5);
      mv(0); mv(2); mv(1);
      chk("u_alive", int'(alive), 0);

      // Length 4 square: stepping onto the tail is legal
      cyc(0, 3, 0, 1);
      cyc(0, 3, 1, 0);
      cyc(1, 3, 0, 0);
      mv(0); mv(2); mv(1);
      chk("tail_alive", int'(alive), 1);
      chk("tail_head_x", hx(0), 450);
      chk("tail_head_y", hy(0), 270);

      // Asynchronous reset mid-run after 10 moves
      cyc(0, 3, 0, 1);
      mv(0);
      repeat (9) cyc(1, 0, 0, 0);
      @(negedge clk);
      tick = 0; grow = 0; restart = 0;
      rst = 1'b0;
      #1;
      m_reset();
      compare_all();
      chk("arst_head_y", hy(0), 270);
      @(negedge clk); rst = 1'b1;

      // Randomized walk
      d = 3;
      for (int n = 0; n < 4000; n++) begin
         tk = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 3);
         g  = ($urandom_range(0, 5) == 0);
         rs = m_alive ? ($urandom_range(0, 599) == 0) : ($urandom_range(0, 7) == 0);
         cyc(tk, d, g, rs);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
